// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// cpu_mem_pkg : MMIO offsets, STATUS bit positions, address-decode enum | rev 1.0
// ============================================================================
package cpu_mem_pkg;

  localparam logic [11:0] OFF_CONSOLE = 12'h000;
  localparam logic [11:0] OFF_STATUS  = 12'h004;
  localparam logic [11:0] OFF_CYCLE   = 12'h008;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERFLOW = 2;

  typedef enum logic [2:0] {
    HIT_RAM,
    HIT_CONSOLE,
    HIT_STATUS,
    HIT_CYCLE,
    HIT_NONE
  } hit_e;

endpackage
`default_nettype wire

// File: rtl/cpu_mem_responder_if.sv
`default_nettype none
// ============================================================================
// cpu_mem_responder_if : core data bus plus console drain stream | rev 1.0
// ============================================================================
interface cpu_mem_responder_if;
  logic        we;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        bad_access;

  modport master (
    output we, address, wdata, out_ready,
    input  rdata, out_valid, out_data, bad_access
  );

  modport slave (
    input  we, address, wdata, out_ready,
    output rdata, out_valid, out_data, bad_access
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with extra-MSB pointers, zero head when empty | rev 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic      [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
endmodule
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// cpu_mem_responder : data-memory responder (RAM + console/status/cycle MMIO) | rev 1.0
// ============================================================================
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input wire logic         clk,
  input wire logic         reset,
  cpu_mem_responder_if.slave bus
);
  localparam int          C_AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] C_RAM_BYTES = 32'(RAM_WORDS * 4);

  hit_e            w_hit;
  logic [C_AW-1:0] w_ram_idx;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [31:0]     w_status;
  logic [31:0]     r_ram [RAM_WORDS];
  logic [31:0]     r_cycle;
  logic            r_overflow;
  logic            r_bad_access;

  // Low two address bits are ignored for decode so misaligned writes land on the enclosing word.
  always_comb begin
    w_hit = HIT_NONE;
    if (bus.address < C_RAM_BYTES) begin
      w_hit = HIT_RAM;
    end else if (bus.address[31:12] == MMIO_BASE[31:12]) begin
      case ({bus.address[11:2], 2'b00})
        OFF_CONSOLE: w_hit = HIT_CONSOLE;
        OFF_STATUS:  w_hit = HIT_STATUS;
        OFF_CYCLE:   w_hit = HIT_CYCLE;
        default:     w_hit = HIT_NONE;
      endcase
    end
  end

  assign w_ram_idx = bus.address[C_AW+1:2];
  assign w_push    = bus.we && (w_hit == HIT_CONSOLE);
  assign w_pop     = bus.out_valid & bus.out_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.wdata),
    .full  (w_full),
    .empty (w_empty),
    .head  (bus.out_data)
  );

  assign bus.out_valid = ~w_empty;

  always_ff @(posedge clk) begin
    if (bus.we && (w_hit == HIT_RAM)) r_ram[w_ram_idx] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle      <= '0;
      r_overflow   <= 1'b0;
      r_bad_access <= 1'b0;
    end else begin
      if (bus.we && (w_hit == HIT_CYCLE)) r_cycle <= bus.wdata;
      else                                r_cycle <= r_cycle + 32'd1;

      // Dropping a word outranks a simultaneous STATUS clear.
      if (w_push && w_full && !w_pop)              r_overflow <= 1'b1;
      else if (bus.we && (w_hit == HIT_STATUS))    r_overflow <= 1'b0;

      if (bus.we && ((w_hit == HIT_NONE) || (bus.address[1:0] != 2'b00)))
        r_bad_access <= 1'b1;
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[STAT_EMPTY]    = w_empty;
    w_status[STAT_FULL]     = w_full;
    w_status[STAT_OVERFLOW] = r_overflow;
  end

  always_comb begin
    bus.rdata = '0;
    case (w_hit)
      HIT_RAM:    bus.rdata = r_ram[w_ram_idx];
      HIT_STATUS: bus.rdata = w_status;
      HIT_CYCLE:  bus.rdata = r_cycle;
      default:    bus.rdata = '0;
    endcase
  end

  assign bus.bad_access = r_bad_access;
endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_cpu_mem_responder : directed self-checking bench for cpu_mem_responder | rev 1.0
// ============================================================================
module tb_cpu_mem_responder;
  localparam logic [31:0] C_CONSOLE = 32'hFFFF_0000;
  localparam logic [31:0] C_STATUS  = 32'hFFFF_0004;
  localparam logic [31:0] C_CYCLE   = 32'hFFFF_0008;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cpu_mem_responder_if bus ();

  cpu_mem_responder #(
    .RAM_WORDS  (256),
    .FIFO_DEPTH (8),
    .MMIO_BASE  (32'hFFFF_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    bus.we      = 1'b1;
    bus.address = addr;
    bus.wdata   = data;
    tick();
    bus.we      = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.address = addr;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.we        = 1'b0;
    bus.address   = 32'h0;
    bus.wdata     = 32'h0;
    bus.out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_bad_access", {31'b0, bus.bad_access}, 32'h0);
    read_chk("rst_status", C_STATUS, 32'h1);
    read_chk("rst_cycle", C_CYCLE, 32'h0);
    reset = 1'b0;

    // RAM write then same-cycle read
    write(32'h10, 32'hDEAD_BEEF);
    read_chk("ram_rd_0x10", 32'h10, 32'hDEAD_BEEF);
    bus.address = 32'h14;
    tick();
    check("ram_rd_untouched_bad", {31'b0, bus.bad_access}, 32'h0);

    // Console fill, overflow, drain, overflow clear
    for (int i = 1; i <= 8; i++) write(C_CONSOLE, i);
    read_chk("con_status_full", C_STATUS, 32'h2);
    write(C_CONSOLE, 32'd9);
    read_chk("con_status_ovf", C_STATUS, 32'h6);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("con_drain_valid", {31'b0, bus.out_valid}, 32'h1);
      check("con_drain_data", bus.out_data, i);
      tick();
    end
    bus.out_ready = 1'b0;
    check("con_drained_valid", {31'b0, bus.out_valid}, 32'h0);
    read_chk("con_status_empty_ovf", C_STATUS, 32'h5);
    write(C_STATUS, 32'h0);
    read_chk("con_status_cleared", C_STATUS, 32'h1);

    // Push and pop on a full FIFO in the same cycle
    for (int i = 0; i < 8; i++) write(C_CONSOLE, 32'h100 + i);
    check("fp_head_before", bus.out_data, 32'h100);
    bus.out_ready = 1'b1;
    write(C_CONSOLE, 32'hAA);
    bus.out_ready = 1'b0;
    read_chk("fp_status", C_STATUS, 32'h2);
    check("fp_head_after", bus.out_data, 32'h101);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("fp_drain_data", bus.out_data, 32'h100 + i);
      tick();
    end
    check("fp_last_valid", {31'b0, bus.out_valid}, 32'h1);
    check("fp_last_data", bus.out_data, 32'hAA);
    tick();
    bus.out_ready = 1'b0;
    check("fp_empty_valid", {31'b0, bus.out_valid}, 32'h0);

    // Cycle counter load and wrap
    write(C_CYCLE, 32'hFFFF_FFFE);
    read_chk("cyc_load", C_CYCLE, 32'hFFFF_FFFE);
    tick();
    check("cyc_max", bus.rdata, 32'hFFFF_FFFF);
    tick();
    check("cyc_wrap", bus.rdata, 32'h0);

    // Unmapped and misaligned writes
    check("bad_before", {31'b0, bus.bad_access}, 32'h0);
    write(32'h8000_0000, 32'h1234_5678);
    check("bad_unmapped", {31'b0, bus.bad_access}, 32'h1);
    read_chk("bad_ram_intact", 32'h10, 32'hDEAD_BEEF);
    do_reset();
    check("bad_after_reset", {31'b0, bus.bad_access}, 32'h0);
    read_chk("ram_survives_reset", 32'h10, 32'hDEAD_BEEF);
    write(32'h0000_0003, 32'hCAFE_F00D);
    check("bad_misaligned", {31'b0, bus.bad_access}, 32'h1);
    read_chk("misaligned_word0", 32'h0, 32'hCAFE_F00D);

    // Reset in the middle of a drain
    do_reset();
    for (int i = 1; i <= 3; i++) write(C_CONSOLE, 32'h30 + i);
    bus.out_ready = 1'b1;
    tick();
    check("mid_head", bus.out_data, 32'h32);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check("mid_rst_data", bus.out_data, 32'h0);
    read_chk("mid_rst_status", C_STATUS, 32'h1);
    read_chk("mid_rst_cycle", C_CYCLE, 32'h0);
    reset = 1'b0;
    bus.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
